// File: rtl/volume_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : volume_pkg
//  Description : Shared types and constants for the volume sample source:
//                pattern mode and FSM state enums, LFSR tap mask and the
//                LFSR next-state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package volume_pkg;

   // Pattern selector, encoded to match the io_mode input
   typedef enum logic [1:0] {
      RAMP   = 2'd0,
      CONST  = 2'd1,
      LFSR   = 2'd2,
      SQUARE = 2'd3
   } mode_e;

   // Source sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Fibonacci taps 16,14,13,11 in right-shift form: the feedback bit is the
   // XOR of state bits 0, 2, 3 and 5 and is shifted in at bit 15.
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {^(s & LFSR_TAP_MASK), s[15:1]};
   endfunction

endpackage : volume_pkg
`default_nettype wire

// File: rtl/volume_sample_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : volume_sample_source_if
//  Description : Valid/ready sample stream with end-of-burst marker.
//                master = producer (source), slave = consumer (integrator).
//  Revision    : 1.0 - initial release
// ============================================================================
interface volume_sample_source_if #(
   parameter int DATA_W = 8
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_bits;
   logic              out_last;

   modport master (
      output out_valid,
      output out_bits,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_bits,
      input  out_last,
      output out_ready
   );
endinterface : volume_sample_source_if
`default_nettype wire

// File: rtl/volume_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : volume_lfsr16
//  Description : 16-bit Fibonacci LFSR (taps 16,14,13,11). Loads the seed on
//                reset and steps once per cycle with advance_i high.
//  Revision    : 1.0 - initial release
// ============================================================================
module volume_lfsr16
   import volume_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] seed_i,
   input  logic        advance_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   // Step only when the consumer accepts a beat
   always_comb begin
      state_d = state_q;
      if (advance_i) begin
         state_d = lfsr16_next(state_q);
      end
   end

   // State register, reloaded with the seed on reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= seed_i;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule : volume_lfsr16
`default_nettype wire

// File: rtl/volume_sample_source.sv
`default_nettype none
// ============================================================================
//  Module      : volume_sample_source
//  Description : Streaming stimulus source. Emits NUM_BURSTS bursts of
//                BURST_LEN samples separated by GAP_CYCLES idle cycles, from a
//                ramp / constant / LFSR / square pattern latched at start.
//                Raises a sticky done flag when the run completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module volume_sample_source
   import volume_pkg::*;
#(
   parameter int          DATA_W     = 8,
   parameter int          BURST_LEN  = 16,
   parameter int          GAP_CYCLES = 4,
   parameter int          NUM_BURSTS = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   io_en,
   input  logic [1:0]             io_mode,
   input  logic [DATA_W-1:0]      io_level,
   volume_sample_source_if.master out_if,
   output logic                   io_done,
   output logic [31:0]            io_sent_count
);

   localparam int BEAT_W  = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
   localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BEAT_W-1:0]  BEAT_LAST     = BEAT_W'(BURST_LEN - 1);
   localparam logic [BURST_W-1:0] BURST_LAST    = BURST_W'(NUM_BURSTS - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST      = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic               LAST_ON_ENTRY = (BURST_LEN == 1);
   localparam logic [DATA_W-1:0]  ALL_ONES      = '1;

   state_e              state_q;
   mode_e               mode_q;
   logic [DATA_W-1:0]   level_q;
   logic                valid_q;
   logic                last_q;
   logic                done_q;
   logic [DATA_W-1:0]   bits_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [BURST_W-1:0]  burst_q;
   logic [GAP_W-1:0]    gap_q;
   logic [31:0]         sent_q;

   logic                fire;
   logic [15:0]         lfsr_state;
   logic [15:0]         lfsr_next;
   logic [DATA_W-1:0]   first_bits;
   logic [DATA_W-1:0]   next_bits;

   assign fire = valid_q & out_if.out_ready;

   volume_lfsr16 u_lfsr (
      .clock     (clock),
      .reset     (reset),
      .seed_i    (LFSR_SEED),
      .advance_i (fire),
      .state_o   (lfsr_state)
   );

   assign lfsr_next = lfsr16_next(lfsr_state);

   // Value of beat 0, taken from the live mode/level at the start edge
   always_comb begin
      first_bits = '0;
      case (mode_e'(io_mode))
         RAMP:    first_bits = '0;
         CONST:   first_bits = io_level;
         LFSR:    first_bits = lfsr_state[DATA_W-1:0];
         SQUARE:  first_bits = ALL_ONES;
         default: first_bits = '0;
      endcase
   end

   // Value of the beat following the one currently presented
   always_comb begin
      next_bits = bits_q;
      case (mode_q)
         RAMP:    next_bits = bits_q + 1'b1;
         CONST:   next_bits = level_q;
         LFSR:    next_bits = lfsr_next[DATA_W-1:0];
         SQUARE:  next_bits = ~bits_q;
         default: next_bits = bits_q;
      endcase
   end

   // Sequencer: burst/beat/gap counting, pattern stepping, registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q  <= RAMP;
         level_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         bits_q  <= '0;
         beat_q  <= '0;
         burst_q <= '0;
         gap_q   <= '0;
         sent_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (io_en) begin
                  state_q <= SEND;
                  mode_q  <= mode_e'(io_mode);
                  level_q <= io_level;
                  bits_q  <= first_bits;
                  valid_q <= 1'b1;
                  last_q  <= LAST_ON_ENTRY;
                  beat_q  <= '0;
                  burst_q <= '0;
               end
            end

            SEND: begin
               if (fire) begin
                  sent_q <= sent_q + 32'd1;
                  bits_q <= next_bits;
                  if (beat_q == BEAT_LAST) begin
                     beat_q  <= '0;
                     burst_q <= burst_q + 1'b1;
                     if (burst_q == BURST_LAST) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else if (GAP_CYCLES == 0) begin
                        last_q <= LAST_ON_ENTRY;
                     end else begin
                        state_q <= GAP;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        gap_q   <= '0;
                     end
                  end else begin
                     beat_q <= beat_q + 1'b1;
                     last_q <= ((beat_q + 1'b1) == BEAT_LAST);
                  end
               end
            end

            GAP: begin
               // Count out the idle window, then wait for enable if needed
               if (gap_q != GAP_LAST) begin
                  gap_q <= gap_q + 1'b1;
               end else if (io_en) begin
                  state_q <= SEND;
                  valid_q <= 1'b1;
                  last_q  <= LAST_ON_ENTRY;
               end
            end

            DONE: begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               done_q  <= 1'b1;
            end

            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_if.out_valid = valid_q;
   assign out_if.out_bits  = bits_q;
   assign out_if.out_last  = last_q;
   assign io_done          = done_q;
   assign io_sent_count    = sent_q;

endmodule : volume_sample_source
`default_nettype wire
